// File: rtl/pll_align_ctrl_mlane.sv
// Multi-lane PLL phase-alignment controller.
// Sweeps a shared phase, then pulses datapath reset until lanes align.
module pll_align_ctrl_mlane #(
  parameter int LANES = 2,
  parameter int PHASE_W = 4,
  parameter int TMR_W = 8,
  parameter int RTY_W = 8,
  parameter int HIST_W = 6,
  parameter logic [HIST_W-1:0] MARGIN = 6'b111100,
  parameter int RST_CYC = 8,
  parameter int STOP_CYC = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               lock,
  input  logic [2*LANES-1:0] align_status,
  input  logic [LANES-1:0]   lane_mask,
  input  logic               reset_datapath,
  output logic [PHASE_W-1:0] phase,
  output logic               reset_datapath_out,
  output logic               stop_out,
  output logic               good_int,
  output logic               err,
  output logic [LANES-1:0]   fail_lane
);

  typedef enum logic [2:0] {
    IDLE, ROTATE, CHECK0, CLEAR,
    RESET_DP, CHECK1, GOOD, ERR
  } state_t;

  localparam logic [TMR_W-1:0] TMR_MAX = '1;
  localparam logic [RTY_W-1:0] RTY_MAX = '1;
  localparam logic [TMR_W-1:0] T1 = TMR_W'(1);
  localparam logic [TMR_W-1:0] T2 = TMR_W'(2);
  localparam logic [TMR_W-1:0] T4 = TMR_W'(4);
  localparam logic [TMR_W-1:0] TMR_PEN = TMR_MAX - T1;
  localparam logic [TMR_W-1:0] RST_T = TMR_W'(RST_CYC);
  localparam logic [TMR_W-1:0] STOP_T = TMR_W'(STOP_CYC);

  state_t state;
  logic lock_reg;
  logic rdp_ff;
  logic [2*LANES-1:0] align_ff;
  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retry;
  logic [HIST_W-1:0] hist;
  logic s0;
  logic s1;
  logic [LANES-1:0] fail_nxt;
  logic go_clear;
  logic counting;

  always_comb begin
    s0 = 1'b0;
    s1 = 1'b0;
    fail_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      s0 = s0 | (align_ff[2*i] & lane_mask[i]);
      s1 = s1 | (align_ff[2*i+1] & lane_mask[i]);
      fail_nxt[i] = lane_mask[i] &
        (align_ff[2*i] | align_ff[2*i+1]);
    end
  end

  // GOOD->CLEAR must restart the timer for the next datapath reset
  assign go_clear = (state == GOOD) && lock_reg &&
                    !s0 && (s1 || rdp_ff);
  assign counting = (state == ROTATE) ||
                    (state == RESET_DP) ||
                    ((state == GOOD) && !go_clear);
  assign err = (state == ERR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lock_reg <= 1'b0;
      rdp_ff <= 1'b0;
      align_ff <= '0;
      timer <= '0;
      retry <= '0;
      hist <= '0;
      phase <= '0;
      reset_datapath_out <= 1'b0;
      stop_out <= 1'b0;
      good_int <= 1'b0;
      fail_lane <= '0;
    end else begin
      lock_reg <= lock;
      rdp_ff <= reset_datapath;
      if (lock_reg) align_ff <= align_status;

      if (!counting) timer <= '0;
      else if (timer != TMR_MAX) timer <= timer + T1;

      if ((state == IDLE) || (state == CLEAR) ||
          (state == GOOD))
        retry <= '0;
      else if (((state == ROTATE) || (state == RESET_DP)) &&
               (timer == T1) && (retry != RTY_MAX))
        retry <= retry + RTY_W'(1);

      if (state == IDLE) hist <= '0;
      else if ((state == ROTATE) && (timer == T2))
        hist <= {hist[HIST_W-2:0], s0};

      if ((state == ROTATE) && (timer == T4))
        phase <= phase + PHASE_W'(1);

      reset_datapath_out <= (state == RESET_DP) &&
                            (timer < RST_T);
      stop_out <= (state == RESET_DP) && (timer < STOP_T);
      good_int <= (state == GOOD) && (timer == TMR_MAX);

      if (state == IDLE) fail_lane <= '0;

      unique case (state)
        IDLE: if (lock_reg) state <= ROTATE;
        ROTATE: begin
          if (retry == RTY_MAX) begin
            state <= ERR;
            fail_lane <= fail_nxt;
          end else if ((timer == TMR_MAX) && lock_reg) begin
            state <= CHECK0;
          end
        end
        CHECK0:
          state <= ((hist == MARGIN) && !s0) ? CLEAR : ROTATE;
        CLEAR: if (!rdp_ff) state <= RESET_DP;
        RESET_DP: begin
          if (retry == RTY_MAX) begin
            state <= ERR;
            fail_lane <= fail_nxt;
          end else if (timer == TMR_PEN) begin
            state <= CHECK1;
          end
        end
        CHECK1: state <= !s1 ? GOOD : RESET_DP;
        GOOD: begin
          if (!lock_reg || s0) state <= IDLE;
          else if (s1 || rdp_ff) state <= CLEAR;
        end
        ERR: begin
          if (!lock_reg) state <= IDLE;
          else if (rdp_ff) state <= CLEAR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
